multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath. It fetches, decodes and sequences each instruction over several clock cycles. It drives the same control signal set as the single-cycle decoder, plus PC/IR write enables and a memory request/ready handshake. It sits between the shared instruction/data memory port and the register file/ALU datapath, and replaces per-cycle combinational decode when the datapath shares one ALU and one memory.

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_LW  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic logic isMemState(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits without mem_ready; flags the last
// allowed wait cycle so the FSM can trap instead of waiting further.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && (count != '1)) begin
      count <= count + 8'd1;
    end
  end

  // count holds prior misses, so this fires on the MEM_TIMEOUT-th miss
  assign timeout = waiting && (count == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/sequence over a shared memory
// port and ALU, with memory timeout and illegal-opcode traps.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       Branch,
  output logic       MemToRead,
  output logic       MemToReg,
  output logic       MemToWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       jump,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  state_t     state, stateNext;
  logic [1:0] causeReg, causeNext;
  logic       inMemState, memWait, memClear, memTimeout;

  assign inMemState = isMemState(state);
  assign memWait    = inMemState && !mem_ready;
  assign memClear   = !inMemState || mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (memClear),
    .waiting (memWait),
    .timeout (memTimeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      causeReg <= TRAP_NONE;
    end else begin
      state    <= stateNext;
      causeReg <= causeNext;
    end
  end

  always_comb begin
    stateNext  = state;
    causeNext  = causeReg;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PC_PLUS4;
    RegDst     = 1'b0;
    Branch     = 1'b0;
    MemToRead  = 1'b0;
    MemToReg   = 1'b0;
    MemToWrite = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    jump       = 1'b0;
    ALUOp      = ALU_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) stateNext = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        MemToRead = 1'b1;
        ALUSrc    = 1'b1;
        ALUOp     = ALU_ADD;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          PCSrc     = PC_PLUS4;
          stateNext = S_DECODE;
        end else if (memTimeout) begin
          stateNext = S_TRAP;
          causeNext = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (Op)
          OP_R:         stateNext = S_EXEC_R;
          OP_ADDI:      stateNext = S_EXEC_I;
          OP_LW, OP_SW: stateNext = S_ADDR;
          OP_BEQ:       stateNext = S_BRANCH;
          OP_J:         stateNext = S_JUMP;
          default: begin
            stateNext = S_TRAP;
            causeNext = TRAP_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUOp     = ALU_FUNCT;
        stateNext = S_WB_R;
      end
      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        ALUOp      = ALU_FUNCT;
        instr_done = 1'b1;
        stateNext  = run ? S_FETCH : S_IDLE;
      end
      S_EXEC_I: begin
        ALUSrc    = 1'b1;
        stateNext = S_WB_I;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        stateNext  = run ? S_FETCH : S_IDLE;
      end
      S_ADDR: begin
        ALUSrc    = 1'b1;
        stateNext = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req   = 1'b1;
        IorD      = 1'b1;
        MemToRead = 1'b1;
        if (mem_ready) begin
          stateNext = S_WB_LW;
        end else if (memTimeout) begin
          stateNext = S_TRAP;
          causeNext = TRAP_TIMEOUT;
        end
      end
      S_WB_LW: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        stateNext  = run ? S_FETCH : S_IDLE;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemToWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          stateNext  = run ? S_FETCH : S_IDLE;
        end else if (memTimeout) begin
          stateNext = S_TRAP;
          causeNext = TRAP_TIMEOUT;
        end
      end
      S_BRANCH: begin
        ALUOp      = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = PC_BRANCH;
        PCWrite    = Zero;
        instr_done = 1'b1;
        stateNext  = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        jump       = 1'b1;
        PCSrc      = PC_JUMP;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        stateNext  = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  assign trap_cause = causeReg;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, corner sequences and
// random stimulus against an instruction-level phase-queue model.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n, run, Zero, mem_ready;
  logic [5:0] Op;
  logic mem_req, IorD, IRWrite, PCWrite, RegDst, Branch, MemToRead, MemToReg;
  logic MemToWrite, ALUSrc, RegWrite, jump, instr_done, trap;
  logic [1:0] PCSrc, trap_cause;
  logic [2:0] ALUOp;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .Op(Op), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst), .Branch(Branch),
    .MemToRead(MemToRead), .MemToReg(MemToReg), .MemToWrite(MemToWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .jump(jump), .ALUOp(ALUOp),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       memReq, iorD, irWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       regDst, branch, memToRead, memToReg, memToWrite, aluSrc, regWrite, jmp;
    logic [2:0] aluOp;
    logic       instrDone, trap;
    logic [1:0] cause;
  } ctl_t;

  ctl_t actCtl, lastCtl;
  always_comb actCtl = {mem_req, IorD, IRWrite, PCWrite, PCSrc, RegDst, Branch,
                        MemToRead, MemToReg, MemToWrite, ALUSrc, RegWrite, jump,
                        ALUOp, instr_done, trap, trap_cause};

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each instruction is a queue of phases; fetch+decode are
  // queued up front and the opcode appends the remaining phases at decode.
  typedef enum int {P_FETCH, P_DEC, P_EXR, P_WBR, P_EXI, P_WBI, P_ADDR,
                    P_MRD, P_WBLW, P_MWR, P_BR, P_J} phase_e;
  phase_e     q[$];
  logic       mTrap;
  logic [1:0] mCause;
  int         waitc;

  task automatic mReset();
    q.delete();
    mTrap  = 1'b0;
    mCause = 2'b00;
    waitc  = 0;
  endtask

  function automatic ctl_t mOut(input logic z, input logic rd);
    ctl_t c = '0;
    c.cause = mCause;
    if (mTrap) begin
      c.trap = 1'b1;
      return c;
    end
    if (q.size() == 0) return c;
    case (q[0])
      P_FETCH: begin
        c.memReq = 1; c.memToRead = 1; c.aluSrc = 1;
        if (rd) begin c.irWrite = 1; c.pcWrite = 1; end
      end
      P_EXR:  c.aluOp = 3'b010;
      P_WBR:  begin c.regDst = 1; c.regWrite = 1; c.aluOp = 3'b010; c.instrDone = 1; end
      P_EXI:  c.aluSrc = 1;
      P_WBI:  begin c.regWrite = 1; c.instrDone = 1; end
      P_ADDR: c.aluSrc = 1;
      P_MRD:  begin c.memReq = 1; c.iorD = 1; c.memToRead = 1; end
      P_WBLW: begin c.memToReg = 1; c.regWrite = 1; c.instrDone = 1; end
      P_MWR:  begin c.memReq = 1; c.iorD = 1; c.memToWrite = 1; c.instrDone = rd; end
      P_BR:   begin c.aluOp = 3'b001; c.branch = 1; c.pcSrc = 2'b01; c.pcWrite = z; c.instrDone = 1; end
      P_J:    begin c.jmp = 1; c.pcSrc = 2'b10; c.pcWrite = 1; c.instrDone = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic mAdvance(input logic r, input logic [5:0] o, input logic z, input logic rd);
    phase_e p;
    ctl_t   c;
    if (mTrap) return;
    if (q.size() == 0) begin
      if (r) q = {P_FETCH, P_DEC};
      return;
    end
    c = mOut(z, rd);
    p = q[0];
    if (p inside {P_FETCH, P_MRD, P_MWR}) begin
      if (rd) begin
        void'(q.pop_front());
        waitc = 0;
      end else begin
        waitc++;
        if (waitc == TIMEOUT) begin
          mTrap = 1'b1; mCause = 2'b10; q.delete();
        end
      end
    end else if (p == P_DEC) begin
      void'(q.pop_front());
      case (o)
        6'b000000: begin q.push_back(P_EXR);  q.push_back(P_WBR); end
        6'b001000: begin q.push_back(P_EXI);  q.push_back(P_WBI); end
        6'b100011: begin q.push_back(P_ADDR); q.push_back(P_MRD); q.push_back(P_WBLW); end
        6'b101011: begin q.push_back(P_ADDR); q.push_back(P_MWR); end
        6'b000100: q.push_back(P_BR);
        6'b000010: q.push_back(P_J);
        default: begin mTrap = 1'b1; mCause = 2'b01; end
      endcase
    end else begin
      void'(q.pop_front());
    end
    if (c.instrDone && r) q = {P_FETCH, P_DEC};
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic rd);
    ctl_t e;
    run = r; Op = o; Zero = z; mem_ready = rd;
    #2;
    e = mOut(z, rd);
    lastCtl = actCtl;
    check("ctl", 32'(actCtl), 32'(e));
    @(posedge clk);
    mAdvance(r, o, z, rd);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after an edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl", 32'(actCtl), 32'h0);
    check("async_reset_state", 32'(state_dbg), 32'(S_IDLE));
    mReset();
    run = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       run;
    logic [5:0] op;
    logic       zero;
    logic       ready;
    logic [3:0] st;
    logic [9:0] key;
  } vec_t;
  vec_t tbl[$];

  logic [9:0] actKey;
  assign actKey = {mem_req, IRWrite, PCWrite, RegWrite, RegDst, MemToReg,
                   instr_done, Branch, PCSrc};

  logic [5:0] legal [6];
  logic [5:0] rop;
  logic       rr, rz, rrd;
  ctl_t       probe;
  int         trapAge;

  initial begin
    legal[0] = OP_R;   legal[1] = OP_LW; legal[2] = OP_SW;
    legal[3] = OP_BEQ; legal[4] = OP_J;  legal[5] = OP_ADDI;

    tbl.push_back('{1'b1, OP_R,    1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b1, OP_R,    1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b1, OP_R,    1'b0, 1'b0, S_EXEC_R, 10'b0000000000});
    tbl.push_back('{1'b1, OP_R,    1'b0, 1'b0, S_WB_R,   10'b0001101000});
    tbl.push_back('{1'b1, OP_BEQ,  1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b1, OP_BEQ,  1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b1, OP_BEQ,  1'b1, 1'b0, S_BRANCH, 10'b0010001101});
    tbl.push_back('{1'b1, OP_BEQ,  1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b1, OP_BEQ,  1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b1, OP_BEQ,  1'b0, 1'b0, S_BRANCH, 10'b0000001101});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_FETCH,  10'b1000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_FETCH,  10'b1000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_FETCH,  10'b1000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_ADDR,   10'b0000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b1, S_MEM_RD, 10'b1000000000});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b0, S_WB_LW,  10'b0001011000});
    tbl.push_back('{1'b1, OP_J,    1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b1, OP_J,    1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b1, OP_J,    1'b0, 1'b0, S_JUMP,   10'b0010001010});
    tbl.push_back('{1'b1, OP_ADDI, 1'b0, 1'b1, S_FETCH,  10'b1110000000});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b0, S_DECODE, 10'b0000000000});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b0, S_EXEC_I, 10'b0000000000});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b0, S_WB_I,   10'b0001001000});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b0, S_IDLE,   10'b0000000000});

    rst_n = 1'b0; run = 1'b0; Op = '0; Zero = 1'b0; mem_ready = 1'b0;
    mReset();
    #3;
    check("reset_ctl", 32'(actCtl), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    run = 1'b1; Op = OP_R;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run = tbl[i].run; Op = tbl[i].op; Zero = tbl[i].zero; mem_ready = tbl[i].ready;
      #2;
      check($sformatf("vec%0d", i), {28'h0, state_dbg}, {28'h0, tbl[i].st});
      check($sformatf("vec%0d_key", i), {22'h0, actKey}, {22'h0, tbl[i].key});
      @(posedge clk); #1;
    end

    // Illegal opcode: sticky trap, run ignored, cleared only by reset
    doReset();
    step(1'b1, 6'h3f, 1'b0, 1'b0);
    step(1'b1, 6'h3f, 1'b0, 1'b1);
    step(1'b1, 6'h3f, 1'b0, 1'b0);
    check("illegal_trap", 32'(trap), 32'd1);
    check("illegal_cause", 32'(trap_cause), 32'd1);
    step(1'b0, 6'h3f, 1'b0, 1'b0);
    step(1'b1, 6'h3f, 1'b1, 1'b0);
    step(1'b0, 6'h3f, 1'b0, 1'b0);
    check("trap_held", 32'(state_dbg), 32'(S_TRAP));

    // sw with memory never ready: traps after TIMEOUT waits
    doReset();
    step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b1);
    step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) step(1'b1, OP_SW, 1'b0, 1'b0);
    check("timeout_trap", 32'(trap), 32'd1);
    check("timeout_cause", 32'(trap_cause), 32'd2);

    // sw with ready on the last permitted wait cycle completes normally
    doReset();
    step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b1);
    step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b1);
    check("edge_ready_done", 32'(lastCtl.instrDone), 32'd1);
    check("edge_ready_no_trap", 32'(trap), 32'd0);
    check("edge_ready_fetch", 32'(state_dbg), 32'(S_FETCH));

    // run dropped during EXEC_R: instruction still completes, then idles
    doReset();
    step(1'b1, OP_R, 1'b0, 1'b0);
    step(1'b1, OP_R, 1'b0, 1'b1);
    step(1'b1, OP_R, 1'b0, 1'b0);
    step(1'b0, OP_R, 1'b0, 1'b0);
    step(1'b0, OP_R, 1'b0, 1'b0);
    check("rundrop_done", 32'(lastCtl.instrDone), 32'd1);
    check("rundrop_idle", 32'(state_dbg), 32'(S_IDLE));

    // Asynchronous reset while MEM_RD is waiting
    step(1'b1, OP_LW, 1'b0, 1'b0);
    step(1'b1, OP_LW, 1'b0, 1'b1);
    step(1'b1, OP_LW, 1'b0, 1'b0);
    step(1'b1, OP_LW, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    check("memrd_req", 32'(mem_req), 32'd1);
    check("memrd_state", 32'(state_dbg), 32'(S_MEM_RD));
    doReset();

    trapAge = 0;
    rop = OP_R;
    for (int n = 0; n < 2500; n++) begin
      if (mTrap) trapAge++;
      if (trapAge > 3) begin
        doReset();
        trapAge = 0;
      end else begin
        if (q.size() == 0 || q[0] == P_FETCH) begin
          if ($urandom_range(0, 19) == 0) rop = 6'($urandom_range(0, 63));
          else rop = legal[$urandom_range(0, 5)];
        end
        rr = ($urandom_range(0, 9) != 0);
        rz = 1'($urandom_range(0, 1));
        probe = mOut(rz, 1'b0);
        rrd = probe.memReq ? ($urandom_range(0, 2) != 0) : 1'b0;
        step(rr, rop, rz, rrd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
